// File: rtl/regfile_scoreboard_if.sv
// Register-file access bundle: read ports, write-back, issue/flush and busy count.
interface regfile_scoreboard_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NR_READ    = 2
);
    logic [NR_READ*ADDR_WIDTH-1:0] raddr;
    logic [NR_READ*DATA_WIDTH-1:0] rdata;
    logic [NR_READ-1:0]            rbusy;
    logic                          wen;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          iss_valid;
    logic [ADDR_WIDTH-1:0]         iss_rd;
    logic                          flush;
    logic [ADDR_WIDTH:0]           busy_cnt;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read, single-write register file with zero register, optional write bypass
// and a one-bit-per-register busy scoreboard driven by issue / write-back / flush.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NR_READ    = 2,
    parameter int unsigned BYPASS     = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);
    localparam int unsigned NR_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam bit          BYP_EN  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0]         rf [NR_REGS];
    logic [NR_REGS-1:0]            busy;
    logic [NR_REGS-1:0]            busy_nxt;
    logic [CNT_W-1:0]              busy_cnt_nxt;
    logic [CNT_W-1:0]              busy_cnt_q;
    logic [NR_READ*DATA_WIDTH-1:0] rdata_c;
    logic [NR_READ-1:0]            rbusy_c;
    logic                          wr_en;

    assign wr_en = bus.wen && (bus.waddr != '0);

    // Read ports; outputs held at zero while reset is asserted.
    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int unsigned i = 0; i < NR_READ; i++) begin
            logic [ADDR_WIDTH-1:0] ra;
            logic                  hit;
            ra  = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit = BYP_EN && bus.wen && (bus.waddr == ra);
            if (rst) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = (hit && ra != '0) ? bus.wdata : rf[ra];
                rbusy_c[i] = busy[ra] & ~hit;
            end
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.busy_cnt = busy_cnt_q;

    // Write-back clears, issue sets (wins over write-back), flush drops everything.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[bus.waddr] = 1'b0;
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end else if (bus.iss_valid && bus.iss_rd != '0) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        busy_cnt_nxt = '0;
        for (int unsigned r = 0; r < NR_REGS; r++) begin
            busy_cnt_nxt = busy_cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NR_REGS; r++) begin
                rf[r] <= '0;
            end
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                rf[bus.waddr] <= bus.wdata;
            end
            busy       <= busy_nxt;
            busy_cnt_q <= busy_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_scoreboard;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;
    localparam int unsigned NR = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) b1 ();
    regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) b0 ();

    assign b0.raddr     = b1.raddr;
    assign b0.wen       = b1.wen;
    assign b0.waddr     = b1.waddr;
    assign b0.wdata     = b1.wdata;
    assign b0.iss_valid = b1.iss_valid;
    assign b0.iss_rd    = b1.iss_rd;
    assign b0.flush     = b1.flush;

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(0)) dut_nob (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b1.wen       = 1'b0;
        b1.waddr     = '0;
        b1.wdata     = '0;
        b1.iss_valid = 1'b0;
        b1.iss_rd    = '0;
        b1.flush     = 1'b0;
    endtask

    function automatic logic [63:0] rd1(input int p);
        return b1.rdata[p*DW +: DW];
    endfunction

    function automatic logic [63:0] rd0(input int p);
        return b0.rdata[p*DW +: DW];
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        b1.raddr = '0;
        idle();
        #12;
        check("rst_busy_cnt", 64'(b1.busy_cnt), 64'd0);
        check("rst_rdata0", rd1(0), 64'd0);
        rst = 1'b1;
        tick();

        // Same-cycle write visible only through the bypass instance.
        b1.wen = 1'b1; b1.waddr = 5'd3; b1.wdata = 64'h1234;
        b1.raddr[0*AW +: AW] = 5'd3;
        #1;
        check("byp_same_cycle", rd1(0), 64'h1234);
        check("nobyp_same_cycle", rd0(0), 64'h0);
        tick();
        idle();
        #1;
        check("nobyp_next_cycle", rd0(0), 64'h1234);
        b1.raddr[1*AW +: AW] = 5'd3;
        #1;
        check("dual_port_p0", rd1(0), 64'h1234);
        check("dual_port_p1", rd1(1), 64'h1234);

        // Zero register: writes and issues to x0 have no effect.
        b1.raddr = '0;
        b1.wen = 1'b1; b1.waddr = 5'd0; b1.wdata = 64'hFFFF;
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd0;
        #1;
        check("x0_rdata_byp", rd1(0), 64'h0);
        check("x0_rbusy", 64'(b1.rbusy), 64'h0);
        tick();
        idle();
        #1;
        check("x0_busy_cnt", 64'(b1.busy_cnt), 64'd0);
        check("x0_rdata_after", rd0(1), 64'h0);

        // Scoreboard: issue rd=7, then write it back.
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd7;
        b1.raddr[1*AW +: AW] = 5'd7;
        #1;
        check("iss_not_yet_busy", 64'(b1.rbusy[1]), 64'd0);
        tick();
        idle();
        #1;
        check("iss_rbusy1", 64'(b1.rbusy[1]), 64'd1);
        check("iss_busy_cnt", 64'(b1.busy_cnt), 64'd1);
        b1.wen = 1'b1; b1.waddr = 5'd7; b1.wdata = 64'h55;
        #1;
        check("wb_byp_rbusy1", 64'(b1.rbusy[1]), 64'd0);
        check("wb_byp_rdata1", rd1(1), 64'h55);
        check("wb_nob_rbusy1", 64'(b0.rbusy[1]), 64'd1);
        check("wb_nob_rdata1", rd0(1), 64'h0);
        tick();
        idle();
        #1;
        check("wb_busy_cnt", 64'(b1.busy_cnt), 64'd0);
        check("wb_rdata1", rd0(1), 64'h55);

        // Simultaneous issue and write-back to rd=9: data lands, busy stays set.
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd9;
        b1.wen = 1'b1; b1.waddr = 5'd9; b1.wdata = 64'hAB;
        b1.raddr[0*AW +: AW] = 5'd9;
        tick();
        idle();
        #1;
        check("sim_rdata", rd1(0), 64'hAB);
        check("sim_rbusy", 64'(b1.rbusy[0]), 64'd1);
        check("sim_busy_cnt", 64'(b1.busy_cnt), 64'd1);
        b1.wen = 1'b1; b1.waddr = 5'd9; b1.wdata = 64'hAB;
        tick();
        idle();
        #1;
        check("sim_clear_cnt", 64'(b1.busy_cnt), 64'd0);

        // Flush drops pending busy marks and a same-cycle issue; the write still lands.
        for (int r = 1; r <= 3; r++) begin
            b1.iss_valid = 1'b1; b1.iss_rd = AW'(r);
            tick();
        end
        idle();
        b1.raddr[0*AW +: AW] = 5'd2;
        #1;
        check("pre_flush_cnt", 64'(b1.busy_cnt), 64'd3);
        check("pre_flush_rbusy2", 64'(b1.rbusy[0]), 64'd1);
        b1.flush = 1'b1; b1.iss_valid = 1'b1; b1.iss_rd = 5'd4;
        b1.wen = 1'b1; b1.waddr = 5'd2; b1.wdata = 64'h77;
        tick();
        idle();
        #1;
        check("flush_busy_cnt", 64'(b1.busy_cnt), 64'd0);
        for (int r = 1; r <= 4; r++) begin
            b1.raddr[0*AW +: AW] = AW'(r);
            #1;
            check($sformatf("flush_rbusy_x%0d", r), 64'(b1.rbusy[0]), 64'd0);
        end
        b1.raddr[0*AW +: AW] = 5'd2;
        #1;
        check("flush_write_kept", rd0(0), 64'h77);

        // Mid-run reset discards stored data and pending busy marks.
        b1.wen = 1'b1; b1.waddr = 5'd5; b1.wdata = 64'hDEAD;
        b1.iss_valid = 1'b1; b1.iss_rd = 5'd6;
        tick();
        idle();
        b1.raddr[0*AW +: AW] = 5'd5;
        #1;
        check("pre_rst_x5", rd0(0), 64'hDEAD);
        check("pre_rst_cnt", 64'(b1.busy_cnt), 64'd1);
        b1.wen = 1'b1; b1.waddr = 5'd5; b1.wdata = 64'hBEEF;
        rst = 1'b0;
        #1;
        check("rst_mid_rdata_byp", rd1(0), 64'h0);
        check("rst_mid_rdata_nob", rd0(0), 64'h0);
        check("rst_mid_busy_cnt", 64'(b1.busy_cnt), 64'd0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        check("post_rst_x5", rd0(0), 64'h0);
        check("post_rst_busy_cnt", 64'(b1.busy_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
